// File: rtl/alu_pkg.sv
// Shared types, widths and the single-cycle logic unit for the ALU datapath.
package alu_pkg;

  localparam int unsigned RESULT_W = 16;
  localparam int unsigned OPND_W   = 8;

  typedef enum logic [2:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4
  } alu_op_e;

  // MUL_WAIT is the multiply state; it cannot share the name of the MUL opcode.
  typedef enum logic [1:0] {
    IDLE,
    EXEC1,
    MUL_WAIT,
    REARM
  } alu_state_e;

  function automatic logic [RESULT_W-1:0] alu_logic(input alu_op_e op,
                                                    input logic [OPND_W-1:0] a,
                                                    input logic [OPND_W-1:0] b);
    logic [OPND_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      ADD:     return {{(RESULT_W-OPND_W-1){1'b0}}, sum};
      AND:     return {{(RESULT_W-OPND_W){1'b0}}, a & b};
      XOR:     return {{(RESULT_W-OPND_W){1'b0}}, a ^ b};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mult_pipe.sv
// Pipelined unsigned multiplier: LATENCY-1 product stages with an async-cleared valid chain.
module alu_mult_pipe
  import alu_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [OPND_W-1:0]   a,
  input  logic [OPND_W-1:0]   b,
  output logic                out_valid,
  output logic [RESULT_W-1:0] product
);

  localparam int unsigned STAGES = LATENCY - 1;

  logic [RESULT_W-1:0] prod_q [STAGES];
  logic [STAGES-1:0]   vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    prod_q[0] <= RESULT_W'(a) * RESULT_W'(b);
    for (int unsigned i = 1; i < STAGES; i++) begin
      prod_q[i] <= prod_q[i-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign product   = prod_q[STAGES-1];

endmodule

// File: rtl/alu_core.sv
// ALU command engine: accept/rearm FSM, operand latch, one-cycle logic unit and
// a pipelined multiplier, with a registered result and one-cycle done pulse.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPND_W-1:0]   A,
  input  logic [OPND_W-1:0]   B,
  input  logic [2:0]          op,
  input  logic                start,
  output logic                done,
  output logic [RESULT_W-1:0] result
);

  alu_state_e          state_q;
  alu_op_e             op_q;
  alu_op_e             op_in;
  logic [OPND_W-1:0]   a_q;
  logic [OPND_W-1:0]   b_q;
  logic                mul_go_q;
  logic                done_q;
  logic [RESULT_W-1:0] result_q;
  logic                mul_valid;
  logic [RESULT_W-1:0] mul_product;

  assign op_in = alu_op_e'(op);

  // Pipe is fed from the latched operands one cycle after accept, so the final
  // product lands exactly MUL_LATENCY edges after the accepting edge.
  alu_mult_pipe #(
    .LATENCY(MUL_LATENCY)
  ) u_mult (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (mul_go_q),
    .a        (a_q),
    .b        (b_q),
    .out_valid(mul_valid),
    .product  (mul_product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= NO_OP;
      a_q      <= '0;
      b_q      <= '0;
      mul_go_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q   <= 1'b0;
      mul_go_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op_in)
              ADD, AND, XOR: begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= op_in;
                state_q <= EXEC1;
              end
              MUL: begin
                a_q      <= A;
                b_q      <= B;
                op_q     <= op_in;
                mul_go_q <= 1'b1;
                state_q  <= MUL_WAIT;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        EXEC1: begin
          result_q <= alu_logic(op_q, a_q, b_q);
          done_q   <= 1'b1;
          state_q  <= REARM;
        end
        MUL_WAIT: begin
          if (mul_valid) begin
            result_q <= mul_product;
            done_q   <= 1'b1;
            state_q  <= REARM;
          end
        end
        REARM: begin
          if (!start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed, table-driven and scoreboarded checks of alu_core.
module tb_alu_core;
  import alu_pkg::*;

  localparam int unsigned MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_core #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .A      (A),
    .B      (B),
    .op     (op),
    .start  (start),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    int unsigned lat;
  } vec_t;

  function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a,
                                        input logic [7:0] b);
    case (o)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input string name, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_res,
                         input int unsigned exp_lat, input int unsigned rearm_hold,
                         input bit scramble);
    int unsigned n;
    bit seen;
    A = a; B = b; op = o; start = 1'b1;
    tick;
    check({name, " done_at_accept"}, 32'(done), 32'd0);
    if (scramble) begin
      A = 8'h00; B = 8'h00;
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick;
      n++;
      if (done) seen = 1'b1;
    end
    check({name, " latency"}, n, exp_lat);
    check({name, " result"}, 32'(result), 32'(exp_res));
    for (int unsigned i = 0; i < rearm_hold; i++) begin
      tick;
      check({name, " rearm_no_done"}, 32'(done), 32'd0);
    end
    start = 1'b0;
    tick;
    check({name, " done_after_drop"}, 32'(done), 32'd0);
  endtask

  task automatic watch_quiet(input string name, input int unsigned cycles,
                             input logic [15:0] exp_res);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      tick;
      if (done) cnt++;
    end
    check({name, " no_done"}, cnt, 0);
    check({name, " result_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [15:0] last;
    logic [2:0]  ro;
    logic [7:0]  ra, rb;

    vecs[0] = '{3'd1, 8'h7F, 8'h01, 16'h0080, 1};
    vecs[1] = '{3'd1, 8'hFF, 8'hFF, 16'h01FE, 1};
    vecs[2] = '{3'd4, 8'hFF, 8'hFF, 16'hFE01, MUL_LAT};
    vecs[3] = '{3'd4, 8'h12, 8'h34, 16'h03A8, MUL_LAT};
    vecs[4] = '{3'd3, 8'hFF, 8'h0F, 16'h00F0, 1};
    vecs[5] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 1};

    #1;
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
              vecs[i].lat, (i == 0) ? 3 : 1, 1'b0);
    end

    run_cmd("mul_scramble", 3'd4, 8'hFF, 8'hFF, 16'hFE01, MUL_LAT, 1, 1'b1);

    run_cmd("b2b_and", 3'd2, 8'hF0, 8'h3C, 16'h0030, 1, 0, 1'b0);
    run_cmd("b2b_xor", 3'd3, 8'hF0, 8'h3C, 16'h00CC, 1, 0, 1'b0);

    op = 3'd0; A = 8'h55; B = 8'hAA; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    op = 3'b110; start = 1'b1;
    tick;
    start = 1'b0;
    watch_quiet("noop_illegal", MUL_LAT + 2, 16'h00CC);
    run_cmd("add_after_illegal", 3'd1, 8'h01, 8'h01, 16'h0002, 1, 0, 1'b0);

    A = 8'h10; B = 8'h10; op = 3'd4; start = 1'b1;
    tick;
    tick;
    reset_n = 1'b0;
    start = 1'b0;
    #1;
    check("midreset done", 32'(done), 32'd0);
    check("midreset result", 32'(result), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    watch_quiet("post_reset", MUL_LAT + 3, 16'h0000);
    run_cmd("add_after_reset", 3'd1, 8'h02, 8'h03, 16'h0005, 1, 0, 1'b0);

    last = 16'h0005;
    for (int k = 0; k < 1000; k++) begin
      ro = 3'($urandom_range(0, 4));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (ro == 3'd0) begin
        A = ra; B = rb; op = ro; start = 1'b1;
        tick;
        start = 1'b0;
        watch_quiet("rand_noop", MUL_LAT + 2, last);
      end else begin
        last = model(ro, ra, rb);
        run_cmd($sformatf("rand%0d op%0d %0h,%0h", k, ro, ra, rb), ro, ra, rb, last,
                (ro == 3'd4) ? MUL_LAT : 1, $urandom_range(0, 2), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
